// File: rtl/muldiv_unit_pkg.sv
// Shared codes for the M-extension multiply/divide unit: ALU class code,
// funct3 operation codes and FSM state encoding.
package muldiv_unit_pkg;

    // ALU operation class that routes an instruction to the mul/div unit
    localparam logic [3:0] ALUOP_M = 4'b0101;

    // M-extension funct3 operation select
    typedef enum logic [2:0] {
        F3_MUL    = 3'b000,
        F3_MULH   = 3'b001,
        F3_MULHSU = 3'b010,
        F3_MULHU  = 3'b011,
        F3_DIV    = 3'b100,
        F3_DIVU   = 3'b101,
        F3_REM    = 3'b110,
        F3_REMU   = 3'b111
    } m_f3_t;

    // Sequencer states
    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COMPUTE = 2'd1,
        S_DONE    = 2'd2
    } state_t;

endpackage

// File: rtl/muldiv_unit_if.sv
// Request/response bundle between the issue stage and the mul/div unit.
interface muldiv_unit_if #(
    parameter int XLEN = 32
);
    logic            valid_in;
    logic [3:0]      ALUOp;
    logic [2:0]      funct3;
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] rs2;
    logic            flush;
    logic            busy;
    logic            valid_out;
    logic [XLEN-1:0] result;

    modport master (
        output valid_in, ALUOp, funct3, rs1, rs2, flush,
        input  busy, valid_out, result
    );

    modport slave (
        input  valid_in, ALUOp, funct3, rs1, rs2, flush,
        output busy, valid_out, result
    );
endinterface

// File: rtl/muldiv_decode.sv
// Combinational funct3 decode: operation kind, operand signedness and
// which half of the double-width product is returned.
module muldiv_decode
    import muldiv_unit_pkg::*;
(
    input  logic [2:0] funct3,
    output logic       is_div,
    output logic       is_rem,
    output logic       signed_a,
    output logic       signed_b,
    output logic       high_sel
);

    // Map each M-op to its control bits
    always_comb begin
        is_div   = 1'b0;
        is_rem   = 1'b0;
        signed_a = 1'b0;
        signed_b = 1'b0;
        high_sel = 1'b0;
        case (m_f3_t'(funct3))
            F3_MUL:    ;
            F3_MULH:   begin high_sel = 1'b1; signed_a = 1'b1; signed_b = 1'b1; end
            F3_MULHSU: begin high_sel = 1'b1; signed_a = 1'b1; end
            F3_MULHU:  high_sel = 1'b1;
            F3_DIV:    begin is_div = 1'b1; signed_a = 1'b1; signed_b = 1'b1; end
            F3_DIVU:   is_div = 1'b1;
            F3_REM:    begin is_div = 1'b1; is_rem = 1'b1; signed_a = 1'b1; signed_b = 1'b1; end
            F3_REMU:   begin is_div = 1'b1; is_rem = 1'b1; end
            default:   ;
        endcase
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RISC-V M-extension unit. Operands are reduced to magnitudes on
// accept, a shift-add multiplier / restoring divider shares one XLEN+1-bit
// adder for XLEN cycles, and the sign is restored in DONE.
module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic         clk,
    input  logic         rst,
    muldiv_unit_if.slave bus
);

    localparam int CW = $clog2(XLEN) + 1;

    state_t              state_reg, state_next;
    logic [CW-1:0]       cnt_reg, cnt_next;
    logic [2*XLEN-1:0]   acc_reg, acc_next;      // {hi, lo}: product or {remainder, quotient}
    logic [XLEN-1:0]     opb_reg, opb_next;      // multiplicand or divisor magnitude
    logic [2:0]          f3_reg, f3_next;
    logic                neg_reg, neg_next;      // negate product / quotient
    logic                neg_rem_reg, neg_rem_next;
    logic                special_reg, special_next;
    logic [XLEN-1:0]     result_reg, result_next;

    logic                is_div, is_rem, signed_a, signed_b, high_sel;
    logic [2:0]          dec_f3;
    logic                accept;
    logic                rs1_neg, rs2_neg;
    logic [XLEN-1:0]     rs1_mag, rs2_mag;
    logic                div_zero, div_ovf;
    logic [XLEN-1:0]     special_val;
    logic [XLEN:0]       add_x, add_y, add_sum;
    logic [XLEN-1:0]     acc_hi, acc_lo;
    logic [2*XLEN-1:0]   prod_fix;
    logic [XLEN-1:0]     fix_val;

    // Incoming funct3 is decoded while idle, the latched one afterwards
    assign dec_f3 = (state_reg == S_IDLE) ? bus.funct3 : f3_reg;

    muldiv_decode u_decode (
        .funct3   (dec_f3),
        .is_div   (is_div),
        .is_rem   (is_rem),
        .signed_a (signed_a),
        .signed_b (signed_b),
        .high_sel (high_sel)
    );

    assign accept  = (state_reg == S_IDLE) && bus.valid_in && (bus.ALUOp == ALUOP_M) && !bus.flush;
    assign acc_hi  = acc_reg[2*XLEN-1:XLEN];
    assign acc_lo  = acc_reg[XLEN-1:0];

    // Operand magnitudes and the two single-cycle division corner cases
    always_comb begin
        rs1_neg     = signed_a && bus.rs1[XLEN-1];
        rs2_neg     = signed_b && bus.rs2[XLEN-1];
        rs1_mag     = rs1_neg ? -bus.rs1 : bus.rs1;
        rs2_mag     = rs2_neg ? -bus.rs2 : bus.rs2;
        div_zero    = is_div && (bus.rs2 == '0);
        div_ovf     = is_div && signed_a && (bus.rs1 == {1'b1, {(XLEN-1){1'b0}}}) && (bus.rs2 == '1);
        special_val = '0;
        if (div_zero)
            special_val = is_rem ? bus.rs1 : '1;
        else if (div_ovf)
            special_val = is_rem ? '0 : bus.rs1;
    end

    // Shared adder: add multiplicand for multiply, subtract divisor for divide
    always_comb begin
        add_x   = is_div ? {acc_hi, acc_lo[XLEN-1]} : {1'b0, acc_hi};
        add_y   = is_div ? ~{1'b0, opb_reg} : {1'b0, opb_reg};
        add_sum = add_x + add_y + (XLEN+1)'(is_div);
    end

    // Sign restoration and half selection applied in DONE
    always_comb begin
        prod_fix = neg_reg ? -acc_reg : acc_reg;
        if (special_reg)
            fix_val = acc_lo;
        else if (is_div && is_rem)
            fix_val = neg_rem_reg ? -acc_hi : acc_hi;
        else if (is_div)
            fix_val = neg_reg ? -acc_lo : acc_lo;
        else if (high_sel)
            fix_val = prod_fix[2*XLEN-1:XLEN];
        else
            fix_val = prod_fix[XLEN-1:0];
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst)
            state_reg <= S_IDLE;
        else
            state_reg <= state_next;
    end

    // FSM next-state logic; flush kills any in-flight operation
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:    if (accept) state_next = (div_zero || div_ovf) ? S_DONE : S_COMPUTE;
            S_COMPUTE: if (bus.flush) state_next = S_IDLE;
                       else if (cnt_reg == CW'(XLEN-1)) state_next = S_DONE;
            S_DONE:    state_next = S_IDLE;
            default:   state_next = S_IDLE;
        endcase
    end

    // FSM outputs; a flushed DONE neither pulses nor updates the result
    always_comb begin
        bus.busy      = (state_reg == S_COMPUTE);
        bus.valid_out = (state_reg == S_DONE) && !bus.flush;
        bus.result    = bus.valid_out ? fix_val : result_reg;
    end

    // Datapath next values: operand capture, one iteration step, result latch
    always_comb begin
        cnt_next     = cnt_reg;
        acc_next     = acc_reg;
        opb_next     = opb_reg;
        f3_next      = f3_reg;
        neg_next     = neg_reg;
        neg_rem_next = neg_rem_reg;
        special_next = special_reg;
        result_next  = result_reg;
        case (state_reg)
            S_IDLE: if (accept) begin
                f3_next      = bus.funct3;
                cnt_next     = '0;
                special_next = div_zero || div_ovf;
                if (div_zero || div_ovf) begin
                    acc_next     = {{XLEN{1'b0}}, special_val};
                    opb_next     = '0;
                    neg_next     = 1'b0;
                    neg_rem_next = 1'b0;
                end else begin
                    acc_next     = {{XLEN{1'b0}}, is_div ? rs1_mag : rs2_mag};
                    opb_next     = is_div ? rs2_mag : rs1_mag;
                    neg_next     = rs1_neg ^ rs2_neg;
                    neg_rem_next = rs1_neg;
                end
            end
            S_COMPUTE: if (!bus.flush) begin
                cnt_next = cnt_reg + CW'(1);
                if (is_div) begin
                    if (!add_sum[XLEN])
                        acc_next = {add_sum[XLEN-1:0], acc_lo[XLEN-2:0], 1'b1};
                    else
                        acc_next = {acc_reg[2*XLEN-2:0], 1'b0};
                end else begin
                    acc_next = acc_lo[0] ? {add_sum, acc_lo[XLEN-1:1]}
                                         : {1'b0, acc_hi, acc_lo[XLEN-1:1]};
                end
            end
            S_DONE: if (!bus.flush) result_next = fix_val;
            default: ;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg     <= '0;
            acc_reg     <= '0;
            opb_reg     <= '0;
            f3_reg      <= '0;
            neg_reg     <= 1'b0;
            neg_rem_reg <= 1'b0;
            special_reg <= 1'b0;
            result_reg  <= '0;
        end else begin
            cnt_reg     <= cnt_next;
            acc_reg     <= acc_next;
            opb_reg     <= opb_next;
            f3_reg      <= f3_next;
            neg_reg     <= neg_next;
            neg_rem_reg <= neg_rem_next;
            special_reg <= special_next;
            result_reg  <= result_next;
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit at XLEN=32: hand-computed results,
// latencies, flush/reset aborts and ignored requests.
module tb_muldiv_unit;
    import muldiv_unit_pkg::*;

    localparam int XLEN = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_pass   = 0;

    muldiv_unit_if #(.XLEN(XLEN)) bus ();

    muldiv_unit #(.XLEN(XLEN)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one op, wait for valid_out, check result, latency, busy count and hold
    task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_res,
                          input int exp_lat, input int exp_busy);
        int lat;
        int busy_cnt;
        lat = 0;
        busy_cnt = 0;
        bus.valid_in = 1'b1;
        bus.ALUOp    = ALUOP_M;
        bus.funct3   = f3;
        bus.rs1      = a;
        bus.rs2      = b;
        tick();
        bus.valid_in = 1'b0;
        lat = 1;
        while (!bus.valid_out && lat < 100) begin
            if (bus.busy) busy_cnt++;
            tick();
            lat++;
        end
        chk({tag, " result"}, 64'(bus.result), 64'(exp_res));
        chk({tag, " latency"}, 64'(lat), 64'(exp_lat));
        chk({tag, " busy_cycles"}, 64'(busy_cnt), 64'(exp_busy));
        chk({tag, " busy_in_done"}, 64'(bus.busy), 64'd0);
        tick();
        chk({tag, " pulse_width"}, 64'(bus.valid_out), 64'd0);
        chk({tag, " hold"}, 64'(bus.result), 64'(exp_res));
        $display("op %-10s f3=%0d rs1=0x%08h rs2=0x%08h -> 0x%08h lat=%0d", tag, f3, a, b, exp_res, lat);
    endtask

    // Count valid_out pulses over a window; none are expected
    task automatic watch_quiet(input string tag, input int cycles);
        int pulses;
        pulses = 0;
        for (int i = 0; i < cycles; i++) begin
            if (bus.valid_out) pulses++;
            tick();
        end
        chk({tag, " no_valid_out"}, 64'(pulses), 64'd0);
    endtask

    initial begin
        bus.valid_in = 1'b0;
        bus.ALUOp    = 4'd0;
        bus.funct3   = 3'd0;
        bus.rs1      = '0;
        bus.rs2      = '0;
        bus.flush    = 1'b0;
        tick();
        tick();
        chk("reset busy", 64'(bus.busy), 64'd0);
        chk("reset valid_out", 64'(bus.valid_out), 64'd0);
        chk("reset result", 64'(bus.result), 64'd0);
        rst = 1'b0;
        tick();

        // Multiply family
        run_op("MUL",     3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 33, 32);
        run_op("MULHU",   3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33, 32);
        run_op("MULH",    3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 33, 32);
        run_op("MULHSU",  3'b010, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 33, 32);
        run_op("MULH_mn", 3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 33, 32);
        run_op("MUL_zero",3'b000, 32'd0,        32'd5,        32'd0,        33, 32);
        // Divide family
        run_op("DIV",     3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33, 32);
        run_op("REM",     3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33, 32);
        run_op("DIVU",    3'b101, 32'd100,      32'd7,        32'd14,       33, 32);
        run_op("REMU",    3'b111, 32'd100,      32'd7,        32'd2,        33, 32);
        run_op("DIV_pn",  3'b100, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 33, 32);
        // Single-cycle corner cases
        run_op("DIV_by0", 3'b100, 32'd1234,     32'd0,        32'hFFFFFFFF, 1, 0);
        run_op("REMU_by0",3'b111, 32'd5,        32'd0,        32'd5,        1, 0);
        run_op("DIV_ovf", 3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1, 0);
        run_op("REM_ovf", 3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1, 0);

        // Flush at COMPUTE cycle 10
        bus.valid_in = 1'b1; bus.ALUOp = ALUOP_M; bus.funct3 = 3'b000;
        bus.rs1 = 32'd9; bus.rs2 = 32'd9;
        tick();
        bus.valid_in = 1'b0;
        for (int i = 0; i < 9; i++) tick();
        chk("flush pre busy", 64'(bus.busy), 64'd1);
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        chk("flush busy", 64'(bus.busy), 64'd0);
        chk("flush result kept", 64'(bus.result), 64'h0);
        $display("flush at COMPUTE cycle 10");
        watch_quiet("flush", 40);
        run_op("DIVU_aft", 3'b101, 32'd1000, 32'd10, 32'd100, 33, 32);

        // Flush and valid_in together in IDLE, and a non-M ALUOp: nothing accepted
        bus.valid_in = 1'b1; bus.flush = 1'b1; bus.funct3 = 3'b000;
        tick();
        bus.flush = 1'b0; bus.valid_in = 1'b0;
        chk("flush_idle busy", 64'(bus.busy), 64'd0);
        bus.valid_in = 1'b1; bus.ALUOp = 4'b0000;
        tick();
        bus.valid_in = 1'b0; bus.ALUOp = ALUOP_M;
        chk("other_aluop busy", 64'(bus.busy), 64'd0);
        $display("idle flush+valid_in and ALUOp=0 ignored");
        watch_quiet("idle_ignore", 40);

        // valid_in while busy is ignored
        bus.valid_in = 1'b1; bus.funct3 = 3'b000; bus.rs1 = 32'd3; bus.rs2 = 32'd4;
        tick();
        bus.rs1 = 32'd50; bus.rs2 = 32'd60;
        for (int i = 0; i < 4; i++) tick();
        bus.valid_in = 1'b0;
        begin
            int lat;
            lat = 5;
            while (!bus.valid_out && lat < 100) begin
                tick();
                lat++;
            end
            chk("busy_ignore result", 64'(bus.result), 64'd12);
            chk("busy_ignore latency", 64'(lat), 64'd33);
        end
        tick();
        $display("valid_in during busy ignored");
        watch_quiet("busy_ignore", 40);

        // Reset at COMPUTE cycle 5
        bus.valid_in = 1'b1; bus.funct3 = 3'b101; bus.rs1 = 32'd100; bus.rs2 = 32'd7;
        tick();
        bus.valid_in = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_mid busy", 64'(bus.busy), 64'd0);
        chk("rst_mid valid_out", 64'(bus.valid_out), 64'd0);
        chk("rst_mid result", 64'(bus.result), 64'd0);
        $display("reset at COMPUTE cycle 5");
        watch_quiet("rst_mid", 40);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 Parameter XLEN, default 32, operand/result width in bits; legal values 8..64, power of two.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 valid_in  input  1  operation request; sampled only in IDLE.
REQ-005 ALUOp  input  4  operation class; 4'b0101 = M-extension; any other value is ignored.
REQ-006 funct3  input  3  M-op select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-007 rs1, rs2  input  XLEN each  operands captured on accept.
REQ-008 flush  input  1  abort in-flight operation (pipeline kill).
REQ-009 busy  output  1  high while an accepted operation has not yet produced valid_out.
REQ-010 valid_out  output  1  one-cycle pulse; result valid this cycle.
REQ-011 result  output  XLEN  operation result; holds last value when valid_out=0.

Function
REQ-012 States: IDLE, COMPUTE, DONE; reset/default state IDLE.
REQ-013 Accept: IDLE & valid_in & ALUOp==4'b0101 & !flush; latch funct3, rs1, rs2.
REQ-014 Accept with no special case -> COMPUTE; one bit per cycle; exactly XLEN COMPUTE cycles, then DONE.
REQ-015 DONE lasts one cycle: valid_out=1, result driven, then IDLE; new accept possible in the cycle after DONE.
REQ-016 Normal latency: valid_out asserted exactly XLEN+1 cycles after accept edge.
REQ-017 busy=1 in COMPUTE only; busy=0 in IDLE and DONE.
REQ-018 MUL returns low XLEN bits of product; MULH/MULHSU/MULHU return high XLEN bits of 2*XLEN product with ss/su/uu signedness respectively.
REQ-019 DIV/REM signed, truncate toward zero; remainder sign = dividend sign; DIVU/REMU unsigned.
REQ-020 Divide-by-zero (rs2==0): quotient all-ones, remainder rs1; skip COMPUTE, go IDLE->DONE (latency 1).
REQ-021 Signed overflow (rs1 = most-negative, rs2 = -1, DIV/REM): quotient rs1, remainder 0; latency 1 as REQ-020.
REQ-022 Multiply operands of zero take the normal path (no early-out); latency fixed per REQ-016.
REQ-023 valid_in while busy or in DONE is ignored; no queueing.
REQ-024 flush in COMPUTE or DONE -> IDLE next cycle, valid_out=0, result unchanged; flush in IDLE blocks accept.
REQ-025 Simultaneous flush and valid_in in IDLE: flush wins, nothing accepted.
REQ-026 Internal iteration counter width clog2(XLEN)+1; no wrap before terminal count.

Reset
REQ-027 rst asserted: next edge state=IDLE, busy=0, valid_out=0, result=0, counter=0, operand registers cleared.
REQ-028 rst mid-operation discards the operation; no valid_out follows.
REQ-029 rst has priority over flush and valid_in.

Structure
REQ-030 ALUOp M-class code, F3 M-op codes and state encoding live in the shared defines file alongside existing F3/ALU codes.
REQ-031 One sub-module, muldiv_decode (combinational): funct3 -> is_div, is_rem, signed-a, signed-b, high-half select.
REQ-032 Datapath: shared XLEN+1-bit add/sub, 2*XLEN shift register; sign fix-up in DONE.

Verification (XLEN=32)
REQ-033 MUL rs1=7, rs2=-3 -> valid_out 33 cycles after accept, result 0xFFFFFFEB; busy high 32 cycles.
REQ-034 MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULH same operands -> 0x00000000.
REQ-035 DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
REQ-036 DIV x/0 -> 0xFFFFFFFF and REMU 5/0 -> 5, each valid_out 1 cycle after accept; DIV 0x80000000/-1 -> 0x80000000, REM -> 0.
REQ-037 flush at COMPUTE cycle 10 -> no valid_out, busy low next cycle, next request accepted normally.
REQ-038 rst at COMPUTE cycle 5 -> all outputs 0 next cycle; valid_in during busy ignored (no second valid_out).
